// File: rtl/m_spi_arbiter_pkg.sv
// Shared definitions for the two-requester SPI arbiter: word width, timeout
// defaults, FSM state encoding and a saturating counter helper.
package m_spi_arbiter_pkg;

    localparam int WORD_W           = 64;
    localparam int START_WAIT_DEF   = 16;
    localparam int XFER_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_BUSY      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/m_rr_grant2.sv
// Two-way round-robin grant. On a tie the requester not granted last wins;
// the last-grant register only moves when the grant is actually taken.
module m_rr_grant2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (take_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/m_spi_arbiter.sv
// Arbitrates two 64-bit requesters onto a single SPI master, one transfer in
// flight, with start/transfer timeouts and a saturating error counter.
module m_spi_arbiter
    import m_spi_arbiter_pkg::*;
#(
    parameter int START_WAIT   = START_WAIT_DEF,
    parameter int XFER_TIMEOUT = XFER_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [1:0]        rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              spi_start,
    output logic [WORD_W-1:0] spi_out,
    input  logic [WORD_W-1:0] spi_in,
    input  logic              spi_status,
    output logic [7:0]        err_count,
    output state_e            dbg_state
);

    localparam int CNT_MAX = (XFER_TIMEOUT > START_WAIT) ? XFER_TIMEOUT : START_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] XT_LAST = CNT_W'(XFER_TIMEOUT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                grant_q;
    logic                spi_start_q;
    logic [WORD_W-1:0]   spi_out_q;
    logic [1:0]          rsp_valid_q;
    logic [WORD_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;

    logic                take;
    logic [1:0]          gnt;
    logic [1:0]          ready;

    // Handshake: reqN_ready is a combinational one-cycle strobe raised only in
    // IDLE for the granted requester; data is accepted on the rising edge where
    // reqN_valid and reqN_ready are both high. Requesters hold data until then.
    assign take  = (state_q == ST_IDLE) && reset_n;
    assign ready = gnt & {2{take}};

    m_rr_grant2 u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   ({req1_valid, req0_valid}),
        .take_i  (take),
        .gnt_o   (gnt)
    );

    assign err_cnt_d = sat_inc8(err_cnt_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            spi_start_q <= 1'b0;
            spi_out_q   <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            spi_start_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (ready != 2'b00) begin
                        grant_q     <= ready[1];
                        spi_out_q   <= ready[1] ? req1_data : req0_data;
                        spi_start_q <= 1'b1;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (spi_status) begin
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end else if (cnt_q == SW_LAST) begin
                        rsp_valid_q <= {grant_q, ~grant_q};
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (!spi_status) begin
                        rsp_valid_q <= {grant_q, ~grant_q};
                        rsp_data_q  <= spi_in;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (cnt_q == XT_LAST) begin
                        rsp_valid_q <= {grant_q, ~grant_q};
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // The response is presented during this cycle; rsp_err_q
                    // doubles as the transfer's error flag.
                    if (rsp_err_q) begin
                        err_cnt_q <= err_cnt_d;
                    end
                    rsp_err_q  <= 1'b0;
                    rsp_data_q <= '0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign spi_start  = spi_start_q;
    assign spi_out    = spi_out_q;
    assign err_count  = err_cnt_q;
    assign dbg_state  = state_q;

endmodule
